// File: rtl/jt49_pkg.sv
// rtl/jt49_pkg.sv - shared state and bus-phase codes for the PSG bus sequencer
package jt49_pkg;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_ADDR = 3'd1;
    localparam logic [2:0] ST_GAP  = 3'd2;
    localparam logic [2:0] ST_DATA = 3'd3;
    localparam logic [2:0] ST_TAIL = 3'd4;

    // {bdir, bc1}
    localparam logic [1:0] BUS_INACT = 2'b00;
    localparam logic [1:0] BUS_READ  = 2'b01;
    localparam logic [1:0] BUS_WRITE = 2'b10;
    localparam logic [1:0] BUS_ADDR  = 2'b11;

    function automatic logic [1:0] phase_bus(input logic [2:0] st, input logic wr);
        logic [1:0] code;
        code = BUS_INACT;
        case (st)
            ST_ADDR: code = BUS_ADDR;
            ST_DATA: code = wr ? BUS_WRITE : BUS_READ;
            default: code = BUS_INACT;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/jt49_bus_seq.sv
// rtl/jt49_bus_seq.sv - turns CPU register requests into BDIR/BC1 phase sequences
module jt49_bus_seq
    import jt49_pkg::*;
#(
    parameter int HOLD      = 2,
    parameter bit SKIP_ADDR = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_wr,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_data,
    output logic       done,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       bdir,
    output logic       bc1,
    output logic [7:0] bus_dout,
    input  logic [7:0] bus_din
);

    localparam logic [3:0] CNT_LOAD = 4'(HOLD - 1);

    logic [2:0] r_state;
    logic [3:0] r_cnt;
    logic       r_wr;
    logic [7:0] r_addr;
    logic [7:0] r_data;
    logic [7:0] r_last_addr;
    logic       r_last_vld;
    logic [1:0] r_bus;
    logic [7:0] r_dout;
    logic [7:0] r_rsp_data;

    logic [2:0] w_next;
    logic       w_last;
    logic       w_skip;
    logic       w_wr;
    logic [7:0] w_addr;
    logic [7:0] w_data;
    logic       w_done;

    assign w_last = (r_cnt == 4'd0);
    assign w_skip = SKIP_ADDR && r_last_vld && (req_addr == r_last_addr);

    // In IDLE the fields being accepted are still on the request inputs.
    assign w_wr   = (r_state == ST_IDLE) ? req_wr   : r_wr;
    assign w_addr = (r_state == ST_IDLE) ? req_addr : r_addr;
    assign w_data = (r_state == ST_IDLE) ? req_data : r_data;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (req_valid) w_next = w_skip ? ST_DATA : ST_ADDR;
            ST_ADDR: if (w_last) w_next = ST_GAP;
            ST_GAP:  if (w_last) w_next = ST_DATA;
            ST_DATA: if (w_last) w_next = ST_TAIL;
            ST_TAIL: if (w_last) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 4'd0;
            r_wr        <= 1'b0;
            r_addr      <= 8'h00;
            r_data      <= 8'h00;
            r_last_addr <= 8'h00;
            r_last_vld  <= 1'b0;
            r_bus       <= BUS_INACT;
            r_dout      <= 8'h00;
            r_rsp_data  <= 8'h00;
        end else begin
            r_state <= w_next;
            if ((w_next != r_state) && (w_next != ST_IDLE)) begin
                r_cnt <= CNT_LOAD;
            end else if (!w_last) begin
                r_cnt <= r_cnt - 4'd1;
            end

            if ((r_state == ST_IDLE) && req_valid) begin
                r_wr   <= req_wr;
                r_addr <= req_addr;
                r_data <= req_data;
            end

            if ((r_state == ST_ADDR) && w_last) begin
                r_last_addr <= r_addr;
                r_last_vld  <= 1'b1;
            end

            if ((r_state == ST_DATA) && w_last && !r_wr) begin
                r_rsp_data <= bus_din;
            end

            // Bus pins follow the state being entered so they change on the same edge.
            r_bus <= phase_bus(w_next, w_wr);
            if (w_next == ST_ADDR) begin
                r_dout <= w_addr;
            end else if ((w_next == ST_DATA) && w_wr) begin
                r_dout <= w_data;
            end
        end
    end

    assign w_done    = (r_state == ST_TAIL) && w_last;
    assign done      = w_done;
    assign rsp_valid = w_done && !r_wr;
    assign req_ready = (r_state == ST_IDLE);
    assign rsp_data  = r_rsp_data;
    assign bdir      = r_bus[1];
    assign bc1       = r_bus[0];
    assign bus_dout  = r_dout;

endmodule

// File: tb/tb_jt49_bus_seq.sv
// tb/tb_jt49_bus_seq.sv - randomized bench for jt49_bus_seq driving a PSG register-file model
`timescale 1ns/1ps
module tb_jt49_bus_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [1:0] bus;
        logic       chk_dout;
        logic [7:0] dout;
        logic       done;
        logic       rsp;
        logic [7:0] rdata;
    } exp_t;

    task automatic chk(input int c, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL c%0d %s: got 0x%0h expected 0x%0h (cycle %0d)", c, name, act, exp, cyc);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_cfg
        localparam int H = (g == 0) ? 2 : 15;
        localparam bit S = (g == 0);

        logic       rst;
        logic       rst_q;
        logic       req_valid;
        logic       req_ready;
        logic       req_wr;
        logic [7:0] req_addr;
        logic [7:0] req_data;
        logic       done;
        logic       rsp_valid;
        logic [7:0] rsp_data;
        logic       bdir;
        logic       bc1;
        logic [7:0] bus_dout;
        logic [7:0] bus_din;
        logic       fin = 1'b0;

        jt49_bus_seq #(.HOLD(H), .SKIP_ADDR(S)) dut (
            .clk(clk), .rst(rst),
            .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
            .req_addr(req_addr), .req_data(req_data),
            .done(done), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
            .bdir(bdir), .bc1(bc1), .bus_dout(bus_dout), .bus_din(bus_din)
        );

        // PSG bus wrapper: latch on 11, write on 10, drive register on 01; regs >= 16 ignored
        logic [7:0] psg [16];
        logic [7:0] wlat;
        always @(posedge clk) begin
            rst_q <= rst;
            if (rst) begin
                for (int i = 0; i < 16; i++) psg[i] <= 8'h00;
                wlat <= 8'h00;
            end else if ({bdir, bc1} == 2'b11) begin
                wlat <= bus_dout;
            end else if (({bdir, bc1} == 2'b10) && (wlat < 8'd16)) begin
                psg[wlat[3:0]] <= bus_dout;
            end
        end
        assign bus_din = (({bdir, bc1} == 2'b01) && (wlat < 8'd16)) ? psg[wlat[3:0]] : 8'hFF;

        // Reference model: an accepted request expands into its whole per-cycle trace
        exp_t       q[$];
        logic [7:0] m_regs [16];
        logic [7:0] m_laddr;
        logic       m_lvld;
        logic [7:0] m_rsp;
        int         n_acc    = 0;
        int         n_done   = 0;
        int         acc_cyc  = 0;
        int         done_cyc = 0;

        task automatic push_req(input logic wr, input logic [7:0] a, input logic [7:0] d);
            exp_t       e;
            logic [7:0] rd;
            rd = (a < 8'd16) ? m_regs[a[3:0]] : 8'hFF;
            if (!(S && m_lvld && (a == m_laddr))) begin
                for (int i = 0; i < H; i++) begin
                    e = '0; e.bus = 2'b11; e.chk_dout = 1'b1; e.dout = a;
                    q.push_back(e);
                end
                for (int i = 0; i < H; i++) begin
                    e = '0;
                    q.push_back(e);
                end
                m_laddr = a;
                m_lvld  = 1'b1;
            end
            for (int i = 0; i < H; i++) begin
                e = '0; e.bus = wr ? 2'b10 : 2'b01; e.chk_dout = wr; e.dout = d;
                q.push_back(e);
            end
            for (int i = 0; i < H; i++) begin
                e = '0;
                e.done  = (i == H - 1);
                e.rsp   = (i == H - 1) && !wr;
                e.rdata = rd;
                q.push_back(e);
            end
            if (wr && (a < 8'd16)) m_regs[a[3:0]] = d;
        endtask

        initial begin
            exp_t e;
            logic idle;
            forever begin
                @(negedge clk);
                idle = 1'b1;
                if (rst_q) begin
                    q.delete();
                    m_lvld = 1'b0;
                    m_rsp  = 8'h00;
                    for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
                    chk(g, "rst bus",      32'({bdir, bc1}), 32'd0);
                    chk(g, "rst done",     32'(done),        32'd0);
                    chk(g, "rst rsp_valid",32'(rsp_valid),   32'd0);
                    chk(g, "rst rsp_data", 32'(rsp_data),    32'd0);
                    chk(g, "rst ready",    32'(req_ready),   32'd1);
                end else if (q.size() != 0) begin
                    idle = 1'b0;
                    e = q.pop_front();
                    chk(g, "bus",       32'({bdir, bc1}), 32'(e.bus));
                    chk(g, "ready",     32'(req_ready),   32'd0);
                    chk(g, "done",      32'(done),        32'(e.done));
                    chk(g, "rsp_valid", 32'(rsp_valid),   32'(e.rsp));
                    if (e.chk_dout) chk(g, "bus_dout", 32'(bus_dout), 32'(e.dout));
                    if (e.rsp) begin
                        chk(g, "rsp_data", 32'(rsp_data), 32'(e.rdata));
                        m_rsp = e.rdata;
                    end
                    if (e.done) done_cyc = cyc;
                end else begin
                    chk(g, "idle bus",       32'({bdir, bc1}), 32'd0);
                    chk(g, "idle ready",     32'(req_ready),   32'd1);
                    chk(g, "idle done",      32'(done),        32'd0);
                    chk(g, "idle rsp_valid", 32'(rsp_valid),   32'd0);
                    chk(g, "held rsp_data",  32'(rsp_data),    32'(m_rsp));
                end
                if (done) n_done++;
                if (idle && !rst && req_valid) begin
                    push_req(req_wr, req_addr, req_data);
                    acc_cyc = cyc;
                    n_acc++;
                end
            end
        end

        task automatic wait_acc(input int start);
            for (int t = 0; (t < 400) && (n_acc == start); t++) begin
                @(posedge clk); #1;
            end
            chk(g, "accept timeout", 32'(n_acc != start), 32'd1);
        endtask

        task automatic send(input logic wr, input logic [7:0] a, input logic [7:0] d);
            int start;
            start     = n_acc;
            req_wr    = wr;
            req_addr  = a;
            req_data  = d;
            req_valid = 1'b1;
            wait_acc(start);
            req_valid = 1'b0;
        endtask

        task automatic wait_idle();
            for (int t = 0; (t < 400) && (q.size() != 0); t++) begin
                @(posedge clk); #1;
            end
            chk(g, "idle timeout", 32'(q.size()), 32'd0);
        endtask

        task automatic do_reset(input int cycles);
            rst = 1'b1;
            repeat (cycles) @(posedge clk);
            #1 rst = 1'b0;
        endtask

        task automatic random_txns(input int n);
            logic [7:0] a;
            for (int i = 0; i < n; i++) begin
                a = ($urandom_range(0, 5) == 0) ? 8'h13 : 8'($urandom_range(0, 3));
                send(1'($urandom_range(0, 1)), a, 8'($urandom));
                if ($urandom_range(0, 9) == 0) begin
                    repeat ($urandom_range(0, 4 * H)) @(posedge clk);
                    #1 do_reset(1);
                end
                wait_idle();
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
            end
        endtask

        if (g == 0) begin : g_seq_fast
            initial begin
                int nd0;
                req_valid = 1'b0; req_wr = 1'b0; req_addr = 8'h00; req_data = 8'h00;
                do_reset(3);
                send(1'b1, 8'h07, 8'h38); wait_idle();
                chk(g, "wr7 latency", 32'(done_cyc - acc_cyc), 32'd8);
                chk(g, "psg reg7", 32'(psg[7]), 32'h38);
                send(1'b0, 8'h07, 8'h00); wait_idle();
                chk(g, "rd7 skip latency", 32'(done_cyc - acc_cyc), 32'd4);
                chk(g, "rd7 data", 32'(rsp_data), 32'h38);
                send(1'b1, 8'h00, 8'h55); wait_idle();
                send(1'b0, 8'h00, 8'h00); wait_idle();
                chk(g, "rd0 skip latency", 32'(done_cyc - acc_cyc), 32'd4);
                chk(g, "rd0 data", 32'(rsp_data), 32'h55);
                send(1'b0, 8'h02, 8'h00); wait_idle();
                chk(g, "rd2 full latency", 32'(done_cyc - acc_cyc), 32'd8);
                chk(g, "rd2 data", 32'(rsp_data), 32'h00);
                // abort a write to reg 8 in its first DATA cycle
                send(1'b1, 8'h08, 8'h0F);
                repeat (4) @(posedge clk);
                #1 rst = 1'b1;
                @(posedge clk);
                #1 rst = 1'b0;
                chk(g, "abort bus", 32'({bdir, bc1}), 32'd0);
                send(1'b0, 8'h08, 8'h00); wait_idle();
                chk(g, "post-reset full latency", 32'(done_cyc - acc_cyc), 32'd8);
                chk(g, "reg8 after abort", 32'(rsp_data), 32'h00);
                // req_valid held high across three requests
                nd0 = n_done;
                req_valid = 1'b1; req_wr = 1'b1; req_addr = 8'h01; req_data = 8'h11;
                wait_acc(n_acc - 0);
                req_data = 8'h22;
                wait_acc(n_acc);
                req_wr = 1'b0;
                wait_acc(n_acc);
                req_valid = 1'b0;
                wait_idle();
                chk(g, "back-to-back done count", 32'(n_done - nd0), 32'd3);
                chk(g, "back-to-back read", 32'(rsp_data), 32'h22);
                random_txns(60);
                fin = 1'b1;
            end
        end else begin : g_seq_slow
            initial begin
                req_valid = 1'b0; req_wr = 1'b0; req_addr = 8'h00; req_data = 8'h00;
                do_reset(3);
                send(1'b1, 8'h05, 8'hA1); wait_idle();
                chk(g, "wr5 latency", 32'(done_cyc - acc_cyc), 32'd60);
                send(1'b1, 8'h05, 8'hA2); wait_idle();
                chk(g, "wr5 again latency", 32'(done_cyc - acc_cyc), 32'd60);
                send(1'b0, 8'h05, 8'h00); wait_idle();
                chk(g, "rd5 latency", 32'(done_cyc - acc_cyc), 32'd60);
                chk(g, "rd5 data", 32'(rsp_data), 32'hA2);
                random_txns(6);
                fin = 1'b1;
            end
        end
    end

    initial begin
        for (int t = 0; (t < 60000) && !(g_cfg[0].fin && g_cfg[1].fin); t++) @(posedge clk);
        if (!(g_cfg[0].fin && g_cfg[1].fin)) begin
            n_vec++;
            n_bad++;
            $display("FAIL global timeout: fast=%0d slow=%0d expected both 1", g_cfg[0].fin, g_cfg[1].fin);
        end
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
